instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, ports listed below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instr_rd_en  input  1  load instr_current from program memory this cycle.
REQ-005 instr_flush  input  1  load NOP (14'h0000) into instr_current this cycle.
REQ-006 pc_incr_en  input  1  PC <= PC+1.
REQ-007 pc_j_en  input  1  PC <= {pclath[4:3], instr_current[10:0]} (GOTO).
REQ-008 pc_call_en  input  1  push PC onto stack, then jump as pc_j_en (CALL).
REQ-009 pc_ret_en  input  1  PC <= top of stack, pop (RETURN/RETLW/RETFIE).
REQ-010 pclath  input  5  PCLATH register value.
REQ-011 pcl_wr_en / pcl_wr_data  input  1 / 8  computed write to PCL: PC <= {pclath[4:0], pcl_wr_data}.
REQ-012 pmem_addr  output  13  program memory read address.
REQ-013 pmem_rdata  input  14  program memory data, synchronous read, 1-cycle latency.
REQ-014 instr_current  output  14  instruction register feeding the decoder.
REQ-015 pc  output  13  current program counter.
REQ-016 stack_ptr  output  3  hardware stack pointer (next free slot).
REQ-017 fetch_valid  output  1  pmem_rdata corresponds to current pc.

Function
REQ-018 pmem_addr SHALL equal pc combinationally.
REQ-019 fetch_valid SHALL be 0 in the cycle after any pc change or reset release, 1 once pc has been stable for one full cycle.
REQ-020 instr_current update priority: instr_flush > instr_rd_en > hold.
REQ-021 instr_rd_en with fetch_valid=1 SHALL load pmem_rdata; with fetch_valid=0 SHALL load 14'h0000 and suppress that cycle's pc_incr_en.
REQ-022 pc update priority: pc_call_en > pc_j_en > pc_ret_en > pcl_wr_en > pc_incr_en > hold; lower-priority requests in the same cycle ignored.
REQ-023 pc_incr_en SHALL wrap 13'h1FFF -> 13'h0000.
REQ-024 Jump target (j/call) SHALL use instr_current value before this edge's instr_current update.
REQ-025 Stack SHALL be 8 entries x 13 bits, circular; call writes entry[stack_ptr] <= pc (pre-update) then stack_ptr+1.
REQ-026 Return SHALL set stack_ptr-1 and pc <= entry[stack_ptr-1]; entries not cleared on pop.
REQ-027 Overflow (9th push) SHALL wrap stack_ptr 7->0 and overwrite entry 0, no flag; underflow SHALL wrap 0->7 and return entry 7.
REQ-028 Flush with increment (skip) SHALL discard the word at pc and advance pc by exactly 1.
REQ-029 Flush with jump/call/return SHALL yield one NOP cycle then fetch from the new pc (2-instruction-cycle branch).
REQ-030 pc_call_en and pc_ret_en together: call wins, stack unchanged by the return.

Reset
REQ-031 rst SHALL immediately force pc=0, instr_current=14'h0000, stack_ptr=0, all stack entries=0, fetch_valid=0, regardless of clk.
REQ-032 Reset asserted mid-instruction SHALL abandon any pending request; first cycle after release observes no enable effects from before reset.

Verification
REQ-033 Reset release, memory word0=14'h3055, word1=14'h0000; one cycle idle, then rd_en+incr -> instr_current=14'h3055, pc=1.
REQ-034 instr_current=14'h2823 (GOTO 0x023), pclath=5'h08, flush+j_en -> instr_current=0, pc=13'h0823, fetch_valid=0 next cycle, 1 after.
REQ-035 pc=5, CALL 0x010 via call_en+flush -> pc=0x010, stack entry0=5, stack_ptr=1; later ret_en+flush -> pc=5, stack_ptr=0.
REQ-036 Nine nested calls from pc=1..9 then nine returns -> 9th push overwrites entry0; returns yield 9,8,...,2, then 9 (wrap).
REQ-037 pc=13'h1FFF, rd_en+incr -> pc=0; rd_en in cycle right after pcl_wr_en (pclath=0, data=8'h40) -> instr_current=0, pc stays 0x040.
REQ-038 rst asserted asynchronously between edges while pc=0x123 with call_en pending -> pc=0, stack_ptr=0 immediately, no push after release.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch: program counter, 8-deep circular return stack, instruction register.
// Program memory is synchronous-read, so fetch_valid marks when pmem_rdata matches pc.
module instruction_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_rd_en,
  input  logic        instr_flush,
  input  logic        pc_incr_en,
  input  logic        pc_j_en,
  input  logic        pc_call_en,
  input  logic        pc_ret_en,
  input  logic [4:0]  pclath,
  input  logic        pcl_wr_en,
  input  logic [7:0]  pcl_wr_data,
  output logic [12:0] pmem_addr,
  input  logic [13:0] pmem_rdata,
  output logic [13:0] instr_current,
  output logic [12:0] pc,
  output logic [2:0]  stack_ptr,
  output logic        fetch_valid
);

  logic [12:0] pc_q, pc_d;
  logic [13:0] instr_q, instr_d;
  logic [2:0]  sp_q, sp_d;
  logic [2:0]  sp_dec;
  logic [12:0] stack_q [8];
  logic        valid_q;
  logic [12:0] jump_target;
  logic        push;
  logic        stall;

  assign sp_dec      = sp_q - 3'd1;
  assign jump_target = {pclath[4:3], instr_q[10:0]};
  // A read of stale memory data loads a NOP and holds pc so the word is refetched.
  assign stall       = instr_rd_en & ~instr_flush & ~valid_q;

  always_comb begin
    pc_d = pc_q;
    sp_d = sp_q;
    push = 1'b0;
    if (pc_call_en) begin
      pc_d = jump_target;
      sp_d = sp_q + 3'd1;
      push = 1'b1;
    end else if (pc_j_en) begin
      pc_d = jump_target;
    end else if (pc_ret_en) begin
      pc_d = stack_q[sp_dec];
      sp_d = sp_dec;
    end else if (pcl_wr_en) begin
      pc_d = {pclath, pcl_wr_data};
    end else if (pc_incr_en && !stall) begin
      pc_d = pc_q + 13'd1;
    end
  end

  always_comb begin
    instr_d = instr_q;
    if (instr_flush) begin
      instr_d = 14'h0000;
    end else if (instr_rd_en) begin
      instr_d = valid_q ? pmem_rdata : 14'h0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      sp_q    <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      sp_q    <= sp_d;
      valid_q <= (pc_d == pc_q);
      if (push) begin
        stack_q[sp_q] <= pc_q;
      end
    end
  end

  assign pmem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr_current = instr_q;
  assign stack_ptr     = sp_q;
  assign fetch_valid   = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: reference model checked every cycle plus directed literal checks.
module tb_instruction_fetch;
  logic        clk;
  logic        rst;
  logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_call_en, pc_ret_en;
  logic [4:0]  pclath;
  logic        pcl_wr_en;
  logic [7:0]  pcl_wr_data;
  logic [12:0] pmem_addr;
  logic [13:0] pmem_rdata;
  logic [13:0] instr_current;
  logic [12:0] pc;
  logic [2:0]  stack_ptr;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;

  logic [13:0] mem [8192];

  instruction_fetch dut (
    .clk(clk), .rst(rst),
    .instr_rd_en(instr_rd_en), .instr_flush(instr_flush),
    .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
    .pc_call_en(pc_call_en), .pc_ret_en(pc_ret_en),
    .pclath(pclath), .pcl_wr_en(pcl_wr_en), .pcl_wr_data(pcl_wr_data),
    .pmem_addr(pmem_addr), .pmem_rdata(pmem_rdata),
    .instr_current(instr_current), .pc(pc),
    .stack_ptr(stack_ptr), .fetch_valid(fetch_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous-read program memory, one cycle latency
  always @(posedge clk) pmem_rdata <= mem[pmem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  logic [12:0] m_pc = '0;
  logic [13:0] m_instr = '0;
  logic [2:0]  m_sp = '0;
  logic [12:0] m_stk [8];
  int          m_stable = 0;
  logic        m_valid;
  logic [12:0] m_old_pc, m_tgt;
  logic [13:0] m_new_instr;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pc = '0; m_instr = '0; m_sp = '0; m_stable = 0;
        for (int i = 0; i < 8; i++) m_stk[i] = '0;
      end else begin
        m_valid  = (m_stable > 0);
        m_old_pc = m_pc;
        m_tgt    = {pclath[4:3], m_instr[10:0]};
        if (instr_flush) m_new_instr = 14'h0;
        else if (instr_rd_en) m_new_instr = m_valid ? mem[m_pc] : 14'h0;
        else m_new_instr = m_instr;
        if (pc_call_en) begin
          m_stk[m_sp] = m_pc;
          m_sp = m_sp + 3'd1;
          m_pc = m_tgt;
        end else if (pc_j_en) begin
          m_pc = m_tgt;
        end else if (pc_ret_en) begin
          m_sp = m_sp - 3'd1;
          m_pc = m_stk[m_sp];
        end else if (pcl_wr_en) begin
          m_pc = {pclath, pcl_wr_data};
        end else if (pc_incr_en && !(instr_rd_en && !instr_flush && !m_valid)) begin
          m_pc = m_pc + 13'd1;
        end
        m_instr  = m_new_instr;
        m_stable = (m_pc == m_old_pc) ? m_stable + 1 : 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("model_pc", {19'd0, pc}, {19'd0, m_pc});
        chk("model_addr", {19'd0, pmem_addr}, {19'd0, m_pc});
        chk("model_instr", {18'd0, instr_current}, {18'd0, m_instr});
        chk("model_sp", {29'd0, stack_ptr}, {29'd0, m_sp});
        chk("model_valid", {31'd0, fetch_valid}, {31'd0, m_stable > 0});
      end
    end
  end

  task automatic cyc(input bit rd, input bit fl, input bit inc, input bit j, input bit call,
                     input bit ret, input bit wr, input logic [4:0] lath, input logic [7:0] data);
    instr_rd_en = rd; instr_flush = fl; pc_incr_en = inc; pc_j_en = j;
    pc_call_en = call; pc_ret_en = ret; pcl_wr_en = wr; pclath = lath; pcl_wr_data = data;
    @(posedge clk);
    #2;
    instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0; pc_j_en = 0;
    pc_call_en = 0; pc_ret_en = 0; pcl_wr_en = 0; pclath = '0; pcl_wr_data = '0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 5'h00, 8'h00);
  endtask

  logic [12:0] ret_exp [9];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 14'h0000;
    mem[0]       = 14'h3055;
    mem[1]       = 14'h0000;
    mem[2]       = 14'h2823;
    mem[5]       = 14'h2010;
    mem[13'h040] = 14'h3FFF;
    mem[13'h1FFF] = 14'h1ABC;
    ret_exp = '{13'd9, 13'd8, 13'd7, 13'd6, 13'd5, 13'd4, 13'd3, 13'd2, 13'd9};
    rst = 1'b1;
    instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0; pc_j_en = 0;
    pc_call_en = 0; pc_ret_en = 0; pcl_wr_en = 0; pclath = '0; pcl_wr_data = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_pc", {19'd0, pc}, 32'h0);
    chk("rst_instr", {18'd0, instr_current}, 32'h0);
    chk("rst_sp", {29'd0, stack_ptr}, 32'h0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'h0);

    // first fetch after reset
    idle();
    chk("first_valid", {31'd0, fetch_valid}, 32'h1);
    cyc(1, 0, 1, 0, 0, 0, 0, 5'h00, 8'h00);
    chk("first_instr", {18'd0, instr_current}, 32'h3055);
    chk("first_pc", {19'd0, pc}, 32'h1);

    // GOTO with flush
    idle();
    cyc(1, 0, 1, 0, 0, 0, 0, 5'h00, 8'h00);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 5'h00, 8'h00);
    chk("goto_load", {18'd0, instr_current}, 32'h2823);
    cyc(0, 1, 0, 1, 0, 0, 0, 5'h08, 8'h00);
    chk("goto_instr", {18'd0, instr_current}, 32'h0);
    chk("goto_pc", {19'd0, pc}, 32'h0823);
    chk("goto_valid0", {31'd0, fetch_valid}, 32'h0);
    idle();
    chk("goto_valid1", {31'd0, fetch_valid}, 32'h1);

    // CALL / RETURN
    cyc(0, 0, 0, 0, 0, 0, 1, 5'h00, 8'h05);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 5'h00, 8'h00);
    chk("call_load", {18'd0, instr_current}, 32'h2010);
    cyc(0, 1, 0, 0, 1, 0, 0, 5'h00, 8'h00);
    chk("call_pc", {19'd0, pc}, 32'h010);
    chk("call_sp", {29'd0, stack_ptr}, 32'h1);
    idle();
    cyc(0, 1, 0, 0, 0, 1, 0, 5'h00, 8'h00);
    chk("ret_pc", {19'd0, pc}, 32'h5);
    chk("ret_sp", {29'd0, stack_ptr}, 32'h0);

    // stale read stalls the increment
    cyc(1, 0, 1, 0, 0, 0, 0, 5'h00, 8'h00);
    chk("stall_instr", {18'd0, instr_current}, 32'h0);
    chk("stall_pc", {19'd0, pc}, 32'h5);

    // call beats return; jump beats return
    idle();
    cyc(0, 0, 0, 0, 1, 1, 0, 5'h00, 8'h00);
    chk("callret_sp", {29'd0, stack_ptr}, 32'h1);
    chk("callret_pc", {19'd0, pc}, 32'h0);
    cyc(0, 0, 0, 1, 0, 1, 0, 5'h00, 8'h00);
    chk("jret_sp", {29'd0, stack_ptr}, 32'h1);
    cyc(0, 0, 0, 0, 0, 1, 0, 5'h00, 8'h00);
    chk("jret_pop_pc", {19'd0, pc}, 32'h5);
    chk("jret_pop_sp", {29'd0, stack_ptr}, 32'h0);

    // nine nested calls, nine returns
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 5'h00, 8'(i));
      cyc(0, 1, 0, 0, 1, 0, 0, 5'h00, 8'h00);
    end
    chk("nest_sp", {29'd0, stack_ptr}, 32'h1);
    for (int k = 0; k < 9; k++) begin
      cyc(0, 1, 0, 0, 0, 1, 0, 5'h00, 8'h00);
      chk("nest_ret_pc", {19'd0, pc}, {19'd0, ret_exp[k]});
    end
    chk("nest_end_sp", {29'd0, stack_ptr}, 32'h0);

    // pc wrap, then read right after a PCL write
    cyc(0, 0, 0, 0, 0, 0, 1, 5'h1F, 8'hFF);
    chk("pcl_pc", {19'd0, pc}, 32'h1FFF);
    idle();
    cyc(1, 0, 1, 0, 0, 0, 0, 5'h00, 8'h00);
    chk("wrap_pc", {19'd0, pc}, 32'h0);
    chk("wrap_instr", {18'd0, instr_current}, 32'h1ABC);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'h00, 8'h40);
    cyc(1, 0, 1, 0, 0, 0, 0, 5'h00, 8'h00);
    chk("pclrd_instr", {18'd0, instr_current}, 32'h0);
    chk("pclrd_pc", {19'd0, pc}, 32'h040);

    // skip: flush with increment
    idle();
    cyc(1, 0, 1, 0, 0, 0, 0, 5'h00, 8'h00);
    chk("pre_skip_instr", {18'd0, instr_current}, 32'h3FFF);
    cyc(0, 1, 1, 0, 0, 0, 0, 5'h00, 8'h00);
    chk("skip_pc", {19'd0, pc}, 32'h042);
    chk("skip_instr", {18'd0, instr_current}, 32'h0);

    // async reset with a call pending
    cyc(0, 0, 0, 0, 0, 0, 1, 5'h01, 8'h23);
    chk("pre_rst_pc", {19'd0, pc}, 32'h123);
    pc_call_en = 1'b1;
    #1 rst = 1'b1;
    pc_call_en = 1'b0;
    #1;
    chk("arst_pc", {19'd0, pc}, 32'h0);
    chk("arst_sp", {29'd0, stack_ptr}, 32'h0);
    chk("arst_valid", {31'd0, fetch_valid}, 32'h0);
    #3 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("post_rst_pc", {19'd0, pc}, 32'h0);
    chk("post_rst_sp", {29'd0, stack_ptr}, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 0, 5'h00, 8'h00);
    chk("cleared_entry_pc", {19'd0, pc}, 32'h0);
    chk("cleared_entry_sp", {29'd0, stack_ptr}, 32'h7);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
